// File: rtl/intr_ctrl_pkg.sv
// Shared state encoding, vector-table layout and address helper for intr_ctrl.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    REQ     = 2'd2,
    SERVICE = 2'd3
  } intr_state_e;

  localparam int unsigned VEC_WORD_0 = 8;
  localparam int unsigned VEC_WORD_1 = 9;
  localparam int unsigned VEC_WORD_2 = 10;
  localparam int unsigned VEC_WORD_3 = 11;

  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0020;

  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [2:0] cause);
    return base + {27'd0, cause, 2'b00};
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle of interrupt lines, CPU handshake and vector-RAM read port around intr_ctrl.
interface intr_ctrl_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq_in;
  logic [NIRQ-1:0] irq_mask;
  logic            int_en;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_rdata;
  logic            cpu_int;
  logic [31:0]     int_vector;
  logic [2:0]      int_cause;
  logic            cpu_ack;
  logic            eret;
  logic [NIRQ-1:0] pending;

  modport master (
    input  irq_in, irq_mask, int_en, mem_rdata, cpu_ack, eret,
    output mem_addr, cpu_int, int_vector, int_cause, pending
  );

  modport slave (
    output irq_in, irq_mask, int_en, mem_rdata, cpu_ack, eret,
    input  mem_addr, cpu_int, int_vector, int_cause, pending
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set request bit.
module intr_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan top-down so the lowest set bit is the last one to claim idx.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[i] ? 3'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches request edges, picks the highest-priority unmasked line,
// fetches its handler address from the vector RAM and runs the ack/eret handshake.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          NIRQ     = 4,
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  intr_ctrl_if.master bus
);

  intr_state_e     state_r;
  intr_state_e     state_s;
  logic [NIRQ-1:0] irq_q_r;
  logic [NIRQ-1:0] pending_r;
  logic            armed_r;
  logic [2:0]      int_cause_r;
  logic [31:0]     int_vector_r;
  logic            cpu_int_r;

  logic [NIRQ-1:0] rise_s;
  logic [NIRQ-1:0] eligible_s;
  logic [NIRQ-1:0] ack_clr_s;
  logic [2:0]      sel_idx_s;
  logic            sel_valid_s;
  logic            ack_s;

  // The first edge after reset only loads irq_q, so levels held through reset are not edges.
  assign rise_s     = armed_r ? (bus.irq_in & ~irq_q_r) : '0;
  assign eligible_s = pending_r & ~bus.irq_mask;
  assign ack_s      = (state_r == REQ) && bus.cpu_ack;

  intr_prio_enc #(.N(NIRQ)) u_prio (
    .req   (eligible_s),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

  // One-hot clear mask for the line being acknowledged.
  always_comb begin
    ack_clr_s = '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_clr_s[i] = ack_s && (int_cause_r == 3'(i));
    end
  end

  // Next-state logic of the request/acknowledge handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.int_en && sel_valid_s) state_s = FETCH;
        else                           state_s = IDLE;
      end
      FETCH: state_s = REQ;
      REQ: begin
        if (bus.cpu_ack)     state_s = SERVICE;
        else if (!bus.int_en) state_s = IDLE;
        else                 state_s = REQ;
      end
      SERVICE: begin
        if (bus.eret) state_s = IDLE;
        else          state_s = SERVICE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, edge-detect, pending and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r      <= IDLE;
      irq_q_r      <= '0;
      pending_r    <= '0;
      armed_r      <= 1'b0;
      int_cause_r  <= 3'd0;
      int_vector_r <= 32'd0;
      cpu_int_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      irq_q_r   <= bus.irq_in;
      armed_r   <= 1'b1;
      pending_r <= (pending_r & ~ack_clr_s) | rise_s;
      cpu_int_r <= (state_s == REQ);
      if ((state_r == IDLE) && (state_s == FETCH)) begin
        int_cause_r <= sel_idx_s;
      end
      if (state_r == FETCH) begin
        int_vector_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr   = vec_addr(VEC_BASE, int_cause_r);
  assign bus.cpu_int    = cpu_int_r;
  assign bus.int_vector = int_vector_r;
  assign bus.int_cause  = int_cause_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: vector table, handshake corner sequences and random episodes.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] ram [0:31];

  intr_ctrl_if #(.NIRQ(4)) bus ();

  intr_ctrl #(.NIRQ(4), .VEC_BASE(32'h20)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr[6:2]];

  typedef struct {
    logic [3:0]  rise;
    logic [3:0]  mask;
    logic [2:0]  cause;
    logic [3:0]  pend_after;
  } vec_t;

  function automatic logic [31:0] exp_vec(input logic [2:0] c);
    case (c)
      3'd0:    return 32'h30;
      3'd1:    return 32'h3c;
      3'd2:    return 32'h54;
      3'd3:    return 32'h68;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [2:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 3'(i);
    return 3'd7;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.irq_in = 4'b0; bus.irq_mask = 4'b0; bus.int_en = 1'b1;
    bus.cpu_ack = 1'b0; bus.eret = 1'b0;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    tick();
  endtask

  // Wait for the request, check it, hold for ack_dly cycles, then ack and eret.
  task automatic service(input string nm, input logic [2:0] c, input int ack_dly);
    int n = 0;
    while (bus.cpu_int !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_req"}, 32'(bus.cpu_int), 32'd1);
    check({nm, "_cause"}, 32'(bus.int_cause), 32'(c));
    check({nm, "_vec"}, bus.int_vector, exp_vec(c));
    check({nm, "_addr"}, bus.mem_addr, 32'h20 + 32'(c) * 32'd4);
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      check({nm, "_hold"}, 32'(bus.cpu_int), 32'd1);
    end
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    check({nm, "_drop"}, 32'(bus.cpu_int), 32'd0);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  initial begin
    vec_t tbl [5];
    tbl[0] = '{rise: 4'b0001, mask: 4'b0000, cause: 3'd0, pend_after: 4'b0000};
    tbl[1] = '{rise: 4'b0110, mask: 4'b0000, cause: 3'd1, pend_after: 4'b0100};
    tbl[2] = '{rise: 4'b1100, mask: 4'b0100, cause: 3'd3, pend_after: 4'b0100};
    tbl[3] = '{rise: 4'b1111, mask: 4'b0001, cause: 3'd1, pend_after: 4'b1101};
    tbl[4] = '{rise: 4'b1000, mask: 4'b0000, cause: 3'd3, pend_after: 4'b0000};

    for (int i = 0; i < 32; i++) ram[i] = 32'hdead_0000 | 32'(i);
    ram[VEC_WORD_0] = 32'h30;
    ram[VEC_WORD_1] = 32'h3c;
    ram[VEC_WORD_2] = 32'h54;
    ram[VEC_WORD_3] = 32'h68;

    bus.irq_in = 4'b0; bus.irq_mask = 4'b0; bus.int_en = 1'b0;
    bus.cpu_ack = 1'b0; bus.eret = 1'b0;
    clrn = 1'b0;
    #2;
    check("rst_cpu_int", 32'(bus.cpu_int), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_vector", bus.int_vector, 32'd0);
    check("rst_cause", 32'(bus.int_cause), 32'd0);
    check("rst_addr", bus.mem_addr, 32'h20);
    do_reset();

    // Single line: exact three-edge latency.
    bus.irq_in = 4'b0001;
    tick();
    check("t1_pend", 32'(bus.pending), 32'h1);
    check("t1_e0_int", 32'(bus.cpu_int), 32'd0);
    tick();
    check("t1_e1_int", 32'(bus.cpu_int), 32'd0);
    check("t1_fetch_addr", bus.mem_addr, 32'h20);
    tick();
    check("t1_e2_int", 32'(bus.cpu_int), 32'd1);
    service("t1", 3'd0, 0);
    check("t1_pend_end", 32'(bus.pending), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_idle", 32'(bus.cpu_int), 32'd0);
    end
    bus.irq_in = 4'b0;
    tick();

    // Simultaneous rises on lines 3 and 1.
    bus.irq_in = 4'b1010;
    tick();
    service("t2a", 3'd1, 1);
    service("t2b", 3'd3, 0);
    bus.irq_in = 4'b0;
    tick();

    // Masked line latches pending but does not interrupt.
    bus.irq_mask = 4'b0100;
    bus.irq_in = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_masked", 32'(bus.cpu_int), 32'd0);
    end
    check("t3_pend", 32'(bus.pending), 32'h4);
    bus.irq_mask = 4'b0;
    service("t3", 3'd2, 0);
    bus.irq_in = 4'b0;
    tick();

    // Withdrawal by dropping int_en in REQ, then reissue.
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = 4'b0;
    for (int n = 0; n < 20 && bus.cpu_int !== 1'b1; n++) tick();
    check("t4_req", 32'(bus.cpu_int), 32'd1);
    bus.int_en = 1'b0;
    tick();
    check("t4_withdraw", 32'(bus.cpu_int), 32'd0);
    check("t4_pend", 32'(bus.pending), 32'h2);
    for (int k = 0; k < 4; k++) tick();
    check("t4_still_off", 32'(bus.cpu_int), 32'd0);
    bus.int_en = 1'b1;
    service("t4", 3'd1, 0);

    // New edge in the same cycle as ack of that line: set wins.
    bus.irq_in = 4'b0001;
    tick();
    bus.irq_in = 4'b0;
    for (int n = 0; n < 20 && bus.cpu_int !== 1'b1; n++) tick();
    check("t5_req", 32'(bus.cpu_int), 32'd1);
    bus.irq_in = 4'b0001;
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    check("t5_pend_kept", 32'(bus.pending), 32'h1);
    check("t5_drop", 32'(bus.cpu_int), 32'd0);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    service("t5b", 3'd0, 0);
    bus.irq_in = 4'b0;
    tick();

    // Asynchronous reset while in REQ with two lines pending.
    bus.irq_in = 4'b1010;
    tick();
    for (int n = 0; n < 20 && bus.cpu_int !== 1'b1; n++) tick();
    check("t6_pend_pre", 32'(bus.pending), 32'ha);
    #2 clrn = 1'b0;
    #1;
    check("t6_int", 32'(bus.cpu_int), 32'd0);
    check("t6_pend", 32'(bus.pending), 32'h0);
    check("t6_vec", bus.int_vector, 32'd0);
    tick();
    clrn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_no_retrig", 32'(bus.cpu_int) | 32'(bus.pending), 32'd0);
    end
    bus.irq_in = 4'b0;
    tick();
    bus.irq_in = 4'b0100;
    service("t6_new", 3'd2, 0);
    bus.irq_in = 4'b0;

    // Vector table of single-service cases, each from a clean reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.irq_mask = tbl[i].mask;
      bus.irq_in = tbl[i].rise;
      tick();
      service($sformatf("tbl%0d", i), tbl[i].cause, 0);
      check($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].pend_after));
    end
    do_reset();

    // Random episodes: pending modelled as a set drained lowest-first.
    for (int ep = 0; ep < 40; ep++) begin
      logic [3:0] r;
      logic [3:0] m;
      logic [3:0] pend;
      logic [2:0] c;
      r = 4'($urandom_range(1, 15));
      m = 4'($urandom_range(0, 15));
      bus.irq_mask = m;
      bus.irq_in = r;
      tick();
      bus.irq_in = 4'b0;
      pend = r;
      while ((pend & ~m) != 4'b0) begin
        c = lowest(pend & ~m);
        service("rnd", c, int'($urandom_range(0, 3)));
        pend = pend & ~(4'b0001 << c);
      end
      for (int k = 0; k < 3; k++) tick();
      check("rnd_masked_pend", 32'(bus.pending), 32'(pend));
      check("rnd_quiet", 32'(bus.cpu_int), 32'd0);
      bus.irq_mask = 4'b0;
      while (pend != 4'b0) begin
        c = lowest(pend);
        service("rnd_unmask", c, int'($urandom_range(0, 2)));
        pend = pend & ~(4'b0001 << c);
      end
      check("rnd_drained", 32'(bus.pending), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
